// File: rtl/vga_sync_gen_if.sv
// Pixel-timing bundle between the VGA sync generator and its consumers
// (renderer, VGA pins) plus the divided pixel-clock level feeding it.
interface vga_sync_gen_if;
    logic       dclk;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       pix_stb;
    logic       frame_start;

    // Sync generator side: samples the divided clock, drives the timing.
    modport master (
        input  dclk,
        output hsync, vsync, video_on, x, y, pix_stb, frame_start
    );

    // Consumer side: supplies the divided clock, receives the timing.
    modport slave (
        output dclk,
        input  hsync, vsync, video_on, x, y, pix_stb, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator running on the master clock. The divided pixel clock
// is treated as a level; its rising edge forms a one-cycle advance strobe that
// steps the horizontal/vertical counters. All timing outputs are registered
// and decoded from the next counter values so they change together.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned HS_POL    = 0,
    parameter int unsigned VS_POL    = 0
) (
    input  logic           clk,
    input  logic           clr,
    vga_sync_gen_if.master vga
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Window bounds are 11 bits wide so an end bound of 1024 still fits.
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic        HS_ACT   = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic        VS_ACT   = (VS_POL != 0) ? 1'b1 : 1'b0;

    logic       dclk_q_r;
    logic [9:0] hc_r;
    logic [9:0] vc_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       video_on_r;
    logic       pix_stb_r;
    logic       frame_start_r;

    logic       adv_s;
    logic       h_wrap_s;
    logic [9:0] hc_next_s;
    logic [9:0] vc_next_s;
    logic       hsync_next_s;
    logic       vsync_next_s;
    logic       video_on_next_s;
    logic       frame_next_s;

    // Previous dclk level; resets high so a level already high at release is not an edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dclk_q_r <= 1'b1;
        end else begin
            dclk_q_r <= vga.dclk;
        end
    end

    assign adv_s    = vga.dclk & ~dclk_q_r;
    assign h_wrap_s = (hc_r == H_LAST);

    // Next counter values: horizontal steps on every advance, vertical on each line wrap.
    always_comb begin
        hc_next_s = hc_r;
        vc_next_s = vc_r;
        if (adv_s) begin
            if (h_wrap_s) begin
                hc_next_s = 10'd0;
                if (vc_r == V_LAST) begin
                    vc_next_s = 10'd0;
                end else begin
                    vc_next_s = vc_r + 10'd1;
                end
            end else begin
                hc_next_s = hc_r + 10'd1;
                vc_next_s = vc_r;
            end
        end else begin
            hc_next_s = hc_r;
            vc_next_s = vc_r;
        end
    end

    // Timing decode from the next counter values so outputs stay mutually consistent.
    always_comb begin
        video_on_next_s = ({1'b0, hc_next_s} < H_VIS) && ({1'b0, vc_next_s} < V_VIS);
        hsync_next_s    = (({1'b0, hc_next_s} >= HS_START) && ({1'b0, hc_next_s} < HS_END))
                          ? HS_ACT : ~HS_ACT;
        vsync_next_s    = (({1'b0, vc_next_s} >= VS_START) && ({1'b0, vc_next_s} < VS_END))
                          ? VS_ACT : ~VS_ACT;
        frame_next_s    = adv_s && (hc_next_s == 10'd0) && (vc_next_s == 10'd0);
    end

    // Counter and output registers; reset parks the position on the last pixel of the frame.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hc_r          <= H_LAST;
            vc_r          <= V_LAST;
            hsync_r       <= ~HS_ACT;
            vsync_r       <= ~VS_ACT;
            video_on_r    <= 1'b0;
            pix_stb_r     <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            hc_r          <= hc_next_s;
            vc_r          <= vc_next_s;
            hsync_r       <= hsync_next_s;
            vsync_r       <= vsync_next_s;
            video_on_r    <= video_on_next_s;
            pix_stb_r     <= adv_s;
            frame_start_r <= frame_next_s;
        end
    end

    assign vga.x           = hc_r;
    assign vga.y           = vc_r;
    assign vga.hsync       = hsync_r;
    assign vga.vsync       = vsync_r;
    assign vga.video_on    = video_on_r;
    assign vga.pix_stb     = pix_stb_r;
    assign vga.frame_start = frame_start_r;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a default 640x480 instance and a tiny
// instance (15x13, active-high hsync) share the clock, reset and dclk stimulus.
// The reference model tracks a linear pixel position per frame and derives
// x/y/sync/video from it with plain arithmetic.
module tb_vga_sync_gen;
    localparam int FA = 800 * 525;
    localparam int FB = 15 * 13;

    logic clk = 1'b0;
    logic clr;

    int   n_cmp;
    int   n_err;
    int   pos_a;
    int   pos_b;
    logic prev_d;
    logic exp_stb;
    logic exp_fs_a;
    logic exp_fs_b;

    vga_sync_gen_if ifa ();
    vga_sync_gen_if ifb ();

    vga_sync_gen u_a (
        .clk (clk),
        .clr (clr),
        .vga (ifa)
    );

    vga_sync_gen #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_VISIBLE (6), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .HS_POL (1), .VS_POL (0)
    ) u_b (
        .clk (clk),
        .clr (clr),
        .vga (ifb)
    );

    always #5 clk = ~clk;

    // Expected output bundle {hsync, vsync, video_on, x, y, pix_stb, frame_start}.
    function automatic logic [24:0] exp_pack(input int pos, input int hv, input int hfp,
                                             input int hs, input int hbp, input int vv,
                                             input int vfp, input int vs, input int hpol,
                                             input int vpol, input logic stb, input logic fs);
        int   ht;
        int   hx;
        int   vy;
        logic hsy;
        logic vsy;
        logic von;
        ht  = hv + hfp + hs + hbp;
        hx  = pos % ht;
        vy  = pos / ht;
        von = (hx < hv) && (vy < vv);
        hsy = ((hx >= hv + hfp) && (hx < hv + hfp + hs)) ? (hpol != 0) : (hpol == 0);
        vsy = ((vy >= vv + vfp) && (vy < vv + vfp + vs)) ? (vpol != 0) : (vpol == 0);
        return {hsy, vsy, von, 10'(hx), 10'(vy), stb, fs};
    endfunction

    function automatic logic [24:0] exp_a();
        return exp_pack(pos_a, 640, 16, 96, 48, 480, 10, 2, 0, 0, exp_stb, exp_fs_a);
    endfunction

    function automatic logic [24:0] exp_b();
        return exp_pack(pos_b, 8, 2, 3, 2, 6, 2, 2, 1, 0, exp_stb, exp_fs_b);
    endfunction

    function automatic logic [24:0] obs_a();
        return {ifa.hsync, ifa.vsync, ifa.video_on, ifa.x, ifa.y, ifa.pix_stb, ifa.frame_start};
    endfunction

    function automatic logic [24:0] obs_b();
        return {ifb.hsync, ifb.vsync, ifb.video_on, ifb.x, ifb.y, ifb.pix_stb, ifb.frame_start};
    endfunction

    // Drive one dclk level for one clk cycle and advance the reference model.
    task automatic step(input logic d);
        logic adv;
        ifa.dclk = d;
        ifb.dclk = d;
        @(posedge clk);
        #1;
        if (clr) begin
            prev_d   = 1'b1;
            pos_a    = FA - 1;
            pos_b    = FB - 1;
            exp_stb  = 1'b0;
            exp_fs_a = 1'b0;
            exp_fs_b = 1'b0;
        end else begin
            adv     = d & ~prev_d;
            prev_d  = d;
            exp_stb = adv;
            if (adv) begin
                pos_a = (pos_a + 1) % FA;
                pos_b = (pos_b + 1) % FB;
            end
            exp_fs_a = adv && (pos_a == 0);
            exp_fs_b = adv && (pos_b == 0);
        end
    endtask

    task automatic test_reset();
        step(1'b0);
        step(1'b1);
        step(1'b0);
        n_cmp++;
        if (obs_a() !== {1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_a: got %h expected %h", obs_a(),
                     {1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 1'b0, 1'b0});
        end
        n_cmp++;
        if (obs_b() !== {1'b0, 1'b1, 1'b0, 10'd14, 10'd12, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_b: got %h expected %h", obs_b(),
                     {1'b0, 1'b1, 1'b0, 10'd14, 10'd12, 1'b0, 1'b0});
        end
    endtask

    task automatic test_first_edge();
        step(1'b1);
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            n_cmp++;
            if (ifa.pix_stb !== 1'b0) begin
                n_err++;
                $display("FAIL held_high_stb: got %b expected 0", ifa.pix_stb);
            end
        end
        step(1'b0);
        step(1'b1);
        n_cmp++;
        if (obs_a() !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL first_edge: got %h expected %h", obs_a(),
                     {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1});
        end
        for (int k = 1; k < 5; k++) begin
            step(1'b0);
            step(1'b1);
            n_cmp++;
            if ({ifa.x, ifa.pix_stb, ifa.frame_start} !== {10'(k), 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL next_edge: got x=%0d stb=%b fs=%b expected x=%0d stb=1 fs=0",
                         ifa.x, ifa.pix_stb, ifa.frame_start, k);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)));
            n_cmp++;
            if (obs_a() !== exp_a()) begin
                n_err++;
                $display("FAIL random_a cycle %0d: got %h expected %h", i, obs_a(), exp_a());
            end
            n_cmp++;
            if (obs_b() !== exp_b()) begin
                n_err++;
                $display("FAIL random_b cycle %0d: got %h expected %h", i, obs_b(), exp_b());
            end
        end
    endtask

    task automatic test_midframe_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)));
        end
        #2;
        clr = 1'b1;
        #1;
        pos_a   = FA - 1;
        pos_b   = FB - 1;
        prev_d  = 1'b1;
        exp_stb = 1'b0;
        n_cmp++;
        if (obs_a() !== {1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: got %h expected %h", obs_a(),
                     {1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 1'b0, 1'b0});
        end
        for (int i = 0; i < 10; i++) begin
            step(1'(i % 2));
            n_cmp++;
            if (obs_a() !== {1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL reset_hold: got %h expected %h", obs_a(),
                         {1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 1'b0, 1'b0});
            end
        end
        step(1'b1);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            n_cmp++;
            if ({ifa.pix_stb, ifa.x} !== {1'b0, 10'd799}) begin
                n_err++;
                $display("FAIL release_high: got stb=%b x=%0d expected stb=0 x=799",
                         ifa.pix_stb, ifa.x);
            end
        end
        step(1'b0);
        step(1'b1);
        n_cmp++;
        if (obs_a() !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL reset_first_edge: got %h expected %h", obs_a(),
                     {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_stall();
        int p0;
        int q;
        int cnt;
        step(1'b1);
        p0  = pos_a;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step((i < 50) ? 1'b0 : 1'b1);
            if (ifa.pix_stb === 1'b1) begin
                cnt++;
            end
            n_cmp++;
            if (obs_a() !== exp_a()) begin
                n_err++;
                $display("FAIL stall_outputs cycle %0d: got %h expected %h", i, obs_a(), exp_a());
            end
        end
        q = (p0 + 1) % FA;
        n_cmp++;
        if (cnt != 1) begin
            n_err++;
            $display("FAIL stall_count: got %0d strobes expected 1", cnt);
        end
        n_cmp++;
        if ({ifa.y, ifa.x} !== {10'(q / 800), 10'(q % 800)}) begin
            n_err++;
            $display("FAIL stall_advance: got x=%0d y=%0d expected x=%0d y=%0d",
                     ifa.x, ifa.y, q % 800, q / 800);
        end
    endtask

    task automatic test_line_wrap();
        for (int i = 0; i < 40000 && pos_a != 8799; i++) begin
            step(~ifa.dclk);
            n_cmp++;
            if (obs_a() !== exp_a()) begin
                n_err++;
                $display("FAIL wrap_run: got %h expected %h", obs_a(), exp_a());
            end
        end
        n_cmp++;
        if ({ifa.x, ifa.y} !== {10'd799, 10'd10}) begin
            n_err++;
            $display("FAIL wrap_reach: got x=%0d y=%0d expected x=799 y=10", ifa.x, ifa.y);
        end
        step(1'b0);
        step(1'b1);
        n_cmp++;
        if ({ifa.x, ifa.y, ifa.pix_stb} !== {10'd0, 10'd11, 1'b1}) begin
            n_err++;
            $display("FAIL line_wrap: got x=%0d y=%0d stb=%b expected x=0 y=11 stb=1",
                     ifa.x, ifa.y, ifa.pix_stb);
        end
        for (int i = 0; i < 4000 && pos_a != 11 * 800 + 752; i++) begin
            step(~ifa.dclk);
            if (exp_stb) begin
                case (pos_a % 800)
                    639, 640: begin
                        n_cmp++;
                        if (ifa.video_on !== 1'((pos_a % 800) == 639)) begin
                            n_err++;
                            $display("FAIL video_edge x=%0d: got %b", pos_a % 800, ifa.video_on);
                        end
                    end
                    655, 656, 751, 752: begin
                        n_cmp++;
                        if (ifa.hsync !== 1'((pos_a % 800) == 655 || (pos_a % 800) == 752)) begin
                            n_err++;
                            $display("FAIL hsync_edge x=%0d: got %b", pos_a % 800, ifa.hsync);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    endtask

    task automatic test_divider();
        int cnt;
        int last;
        int p0;
        int q;
        cnt  = 0;
        last = -1;
        p0   = pos_a;
        for (int i = 0; i < 9600; i++) begin
            step(1'((i / 3) % 2));
            if (ifa.pix_stb === 1'b1) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (i - last != 6) begin
                        n_err++;
                        $display("FAIL divider_interval: got %0d clk expected 6", i - last);
                    end
                end
                last = i;
                cnt++;
            end
            n_cmp++;
            if (obs_a() !== exp_a()) begin
                n_err++;
                $display("FAIL divider_outputs cycle %0d: got %h expected %h", i, obs_a(), exp_a());
            end
        end
        q = (p0 + 1600) % FA;
        n_cmp++;
        if (cnt != 1600 || {ifa.y, ifa.x} !== {10'(q / 800), 10'(q % 800)}) begin
            n_err++;
            $display("FAIL divider_count: got %0d strobes at x=%0d y=%0d expected 1600 at x=%0d y=%0d",
                     cnt, ifa.x, ifa.y, q % 800, q / 800);
        end
    endtask

    task automatic test_frame();
        int   nstb;
        int   nvs;
        int   nhs;
        int   nvid;
        logic found;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(~ifb.dclk);
            found = (ifb.frame_start === 1'b1);
        end
        nstb = 1;
        nvs  = (ifb.vsync === 1'b0) ? 1 : 0;
        nhs  = (ifb.hsync === 1'b1) ? 1 : 0;
        nvid = (ifb.video_on === 1'b1) ? 1 : 0;
        if (found) begin
            found = 1'b0;
            for (int i = 0; i < 1000 && !found; i++) begin
                step(~ifb.dclk);
                n_cmp++;
                if (ifb.frame_start !== exp_fs_b) begin
                    n_err++;
                    $display("FAIL frame_strobe: got %b expected %b", ifb.frame_start, exp_fs_b);
                end
                if (ifb.frame_start === 1'b1) begin
                    found = 1'b1;
                end else if (ifb.pix_stb === 1'b1) begin
                    nstb++;
                    nvs  += (ifb.vsync === 1'b0) ? 1 : 0;
                    nhs  += (ifb.hsync === 1'b1) ? 1 : 0;
                    nvid += (ifb.video_on === 1'b1) ? 1 : 0;
                end
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL frame_timeout: no pair of frame_start pulses within bound");
        end
        n_cmp++;
        if (nstb != 195) begin
            n_err++;
            $display("FAIL frame_len: got %0d strobes expected 195", nstb);
        end
        n_cmp++;
        if (nvs != 30 || nhs != 39) begin
            n_err++;
            $display("FAIL frame_sync: got vsync=%0d hsync=%0d expected 30 39", nvs, nhs);
        end
        n_cmp++;
        if (nvid != 48) begin
            n_err++;
            $display("FAIL frame_video: got %0d expected 48", nvid);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        clr      = 1'b1;
        ifa.dclk = 1'b0;
        ifb.dclk = 1'b0;
        prev_d   = 1'b1;
        pos_a    = FA - 1;
        pos_b    = FB - 1;
        exp_stb  = 1'b0;
        exp_fs_a = 1'b0;
        exp_fs_b = 1'b0;
        test_reset();
        test_first_edge();
        test_random();
        test_midframe_reset();
        test_stall();
        test_line_wrap();
        test_divider();
        test_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Consumer of the divided pixel clock `dclk` from the clock divider. It runs entirely on the 100 MHz master `clk` and treats `dclk` as a level signal. It edge-detects `dclk` to form a one-cycle pixel strobe, and advances horizontal and vertical pixel counters on each strobe. Its outputs are registered 640x480@60 VGA timing signals: `hsync`, `vsync`, `video_on`, `x`, `y`, and frame/pixel strobes, which feed the game renderer and the VGA pins.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)

Ports:
clk  input  1  master clock, 100 MHz
clr  input  1  reset, asynchronous, active-high
dclk  input  1  divided pixel clock level from clock divider, synchronous to clk
hsync  output  1  horizontal sync, polarity per HS_POL
vsync  output  1  vertical sync, polarity per VS_POL
video_on  output  1  high when (x,y) is in the visible area
x  output  10  current horizontal count
y  output  10  current vertical count
pix_stb  output  1  one-clk pulse, high in the cycle the outputs take a new pixel's values
frame_start  output  1  one-clk pulse, high with pix_stb when (x,y) becomes (0,0)

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525). Both must be ≤ 1024. The counters are 10-bit unsigned.
- Edge detect: `dclk_q` is `dclk` registered on `clk`. `adv = dclk & ~dclk_q`, which is combinational.
- `dclk` constant high or constant low means no advance. All outputs hold their values and `pix_stb` stays 0.
- When `adv` is high at a `clk` rising edge:
  - `hc` becomes `hc+1`. If `hc == H_TOTAL-1`, `hc` becomes 0 instead.
  - `vc` increments only when `hc` wraps. If `vc == V_TOTAL-1` at that wrap, `vc` becomes 0.
- Outputs are registered and computed from the next counter values. This keeps `x`, `y`, `hsync`, `vsync` and `video_on` mutually consistent and glitch-free.
  - `x = hc`, `y = vc`.
  - `video_on = (hc < H_VISIBLE) && (vc < V_VISIBLE)`.
  - `hsync` is active for `hc` in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]; default 656..751.
  - `vsync` is active for `vc` in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1]; default 490..491, for every `hc` on those lines.
- `pix_stb` is registered: it equals `adv`, so it is high for exactly one `clk` cycle alongside the updated outputs.
- `frame_start` is registered: it is high when `adv` is high and both counters wrap to 0.
- Reset (`clr` high, asynchronous, at any time including mid-frame):
  - `hc = H_TOTAL-1`, `vc = V_TOTAL-1`, `dclk_q = 1`.
  - `hsync` and `vsync` at their inactive levels; `video_on = 0`; `x = H_TOTAL-1`; `y = V_TOTAL-1`; `pix_stb = 0`; `frame_start = 0`.
- After `clr` deasserts, the first genuine 0→1 transition of `dclk` produces `x=0`, `y=0`, `video_on=1`, `pix_stb=1`, `frame_start=1`. Because `dclk_q` resets to 1, a `dclk` that is already high at release is not counted as an edge.
- While `clr` is high, `dclk` activity is ignored.
- Minimum legal `dclk` period is 2 `clk` cycles (high ≥1, low ≥1). Pulses narrower than that are out of scope.

Test Plan:
- Reset: assert `clr` mid-frame with `dclk` toggling → next cycle `x=799`, `y=524`, `hsync=1`, `vsync=1`, `video_on=0`, strobes 0; hold `dclk=1` through release → no `pix_stb` until a 0→1 transition.
- First edge after reset → same cycle as `pix_stb=1`: `x=0`, `y=0`, `video_on=1`, `frame_start=1`. Subsequent edges → `x=1,2,...` with `frame_start=0`.
- Line wrap: drive to `x=799`, `y=10`, then one edge → `x=0`, `y=11`. At `x=639`→640, `video_on` 1→0. `hsync` goes low at `x=656` and high at `x=752`.
- Frame: count `pix_stb` between consecutive `frame_start` pulses → exactly 420000. `vsync` is low exactly on `y=490..491` (1600 strobes). `video_on` is high for exactly 307200 strobes.
- Stall: hold `dclk` low for 50 clk, then high for 50 clk → exactly one `pix_stb`, counters advance by 1, outputs stable otherwise.
- Divider pattern: `dclk` toggling every 3 clk (period 6) → `pix_stb` every 6 clk with no missed or double counts over 2 full lines.
